// File: rtl/escalonador_round_robin.sv
// Round-robin process scheduler: quantum counting, PC save/restore and context-switch pulse generation.
// Optional I/O blocking of slots is compiled in with `define SCHED_IO_BLOCK_EN.
module escalonador_round_robin #(
  parameter int NUM_PROC = 8,
  parameter int QUANTUM  = 16,
  parameter int PC_W     = 32,
  localparam int ID_W    = $clog2(NUM_PROC)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            instr_valid,
  input  logic [PC_W-1:0] pc,
  input  logic            fim_processo,
  input  logic            instrucao_io,
  input  logic            io_done,
  input  logic [ID_W-1:0] io_done_id,
  input  logic            proc_load,
  input  logic [ID_W-1:0] proc_load_id,
  input  logic [PC_W-1:0] proc_load_pc,
  output logic            troca_contexto,
  output logic [PC_W-1:0] pc_retorno,
  output logic [31:0]     processo_atual,
  output logic            intrucao_io_contexto,
  output logic            ocioso,
  output logic [7:0]      quantum_restante
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SAVE,
    S_SELECT,
    S_DISPATCH
  } state_e;

  state_e              state_q;
  logic [NUM_PROC-1:0] valid_q;
  logic [NUM_PROC-1:0] runnable;
  logic [PC_W-1:0]     pc_table_q [NUM_PROC];
  logic [ID_W-1:0]     atual_q;
  logic                from_idle_q;
  logic                cause_end_q;
  logic                cause_io_q;
  logic [7:0]          quantum_q;
  logic                troca_q;
  logic                io_ctx_q;
  logic [PC_W-1:0]     pc_ret_q;

  logic [ID_W-1:0]     base_d;
  logic [ID_W-1:0]     idx_d;
  logic [ID_W-1:0]     sel_d;
  logic                sel_found_d;

`ifdef SCHED_IO_BLOCK_EN
  logic [NUM_PROC-1:0] blocked_q;
  assign runnable = valid_q & ~blocked_q;
`else
  logic unused_io;
  assign unused_io = ^{io_done, io_done_id};
  assign runnable  = valid_q;
`endif

  // Circular search: from IDLE the current slot is a candidate first, after a
  // save the search starts one past it and only reaches it again last.
  always_comb begin
    base_d      = from_idle_q ? atual_q : atual_q + ID_W'(1);
    idx_d       = '0;
    sel_d       = '0;
    sel_found_d = 1'b0;
    for (int k = NUM_PROC - 1; k >= 0; k--) begin
      idx_d = base_d + ID_W'(k);
      if (runnable[idx_d]) begin
        sel_d       = idx_d;
        sel_found_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      atual_q     <= '0;
      from_idle_q <= 1'b0;
      cause_end_q <= 1'b0;
      cause_io_q  <= 1'b0;
      quantum_q   <= 8'(QUANTUM);
      troca_q     <= 1'b0;
      io_ctx_q    <= 1'b0;
      pc_ret_q    <= '0;
      for (int i = 0; i < NUM_PROC; i++) pc_table_q[i] <= '0;
`ifdef SCHED_IO_BLOCK_EN
      blocked_q   <= '0;
`endif
    end else begin
      troca_q  <= 1'b0;
      io_ctx_q <= 1'b0;
`ifdef SCHED_IO_BLOCK_EN
      // Written before the SAVE update so a same-cycle I/O save keeps the slot blocked.
      if (io_done) blocked_q[io_done_id] <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (enable && (|runnable)) begin
            from_idle_q <= 1'b1;
            cause_end_q <= 1'b0;
            cause_io_q  <= 1'b0;
            state_q     <= S_SELECT;
          end
        end
        S_RUN: begin
          if (!enable) begin
            state_q <= S_IDLE;
          end else begin
            if (instr_valid) quantum_q <= quantum_q - 8'd1;
            if (fim_processo) begin
              cause_end_q <= 1'b1;
              cause_io_q  <= 1'b0;
              state_q     <= S_SAVE;
            end else if (instrucao_io) begin
              cause_end_q <= 1'b0;
              cause_io_q  <= 1'b1;
              state_q     <= S_SAVE;
            end else if (instr_valid && quantum_q == 8'd1) begin
              cause_end_q <= 1'b0;
              cause_io_q  <= 1'b0;
              state_q     <= S_SAVE;
            end
          end
        end
        S_SAVE: begin
          pc_table_q[atual_q] <= pc;
          if (cause_end_q) valid_q[atual_q] <= 1'b0;
`ifdef SCHED_IO_BLOCK_EN
          if (cause_io_q) blocked_q[atual_q] <= 1'b1;
`endif
          from_idle_q <= 1'b0;
          state_q     <= S_SELECT;
        end
        S_SELECT: begin
          if (sel_found_d) begin
            atual_q   <= sel_d;
            pc_ret_q  <= pc_table_q[sel_d];
            troca_q   <= 1'b1;
            io_ctx_q  <= cause_io_q;
            quantum_q <= 8'(QUANTUM);
            state_q   <= S_DISPATCH;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DISPATCH: state_q <= S_RUN;
        default:    state_q <= S_IDLE;
      endcase
      // Placed last so a load overrides a same-cycle save to the same slot.
      if (proc_load) begin
        valid_q[proc_load_id]    <= 1'b1;
        pc_table_q[proc_load_id] <= proc_load_pc;
`ifdef SCHED_IO_BLOCK_EN
        blocked_q[proc_load_id]  <= 1'b0;
`endif
      end
    end
  end

  // The CPU loads pc_retorno in the single cycle troca_contexto is high; there is no back-pressure.
  assign troca_contexto       = troca_q;
  assign pc_retorno           = pc_ret_q;
  assign processo_atual       = 32'(atual_q);
  assign intrucao_io_contexto = io_ctx_q;
  assign ocioso               = ~(|runnable);
  assign quantum_restante     = quantum_q;

endmodule

// File: doc/escalonador_round_robin.md
# escalonador_round_robin

Round-robin process scheduler that sequences the CPU's multiprogrammed execution. Holds a table of runnable process slots and their saved PCs, counts the quantum in retired instructions, and on expiry, process end or I/O issue, saves the running PC and selects the next runnable slot. It drives the context-switch request and restart PC into the CPU's PC-update logic, and supplies the current process number used for relative addressing and branch correction.

## Interface
**Parameters**
- `NUM_PROC`, 8: number of process slots; power of two, 2..16.
- `QUANTUM`, 16: instructions per time slice; 1..255.
- `PC_W`, 32: PC width.

**Ports**
- `clock`  in  1: system clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: scheduling allowed; low while BIOS executes.
- `instr_valid`  in  1: one instruction retired this cycle.
- `pc`  in  PC_W: PC of the running process; sampled when the save occurs.
- `fim_processo`  in  1: running process executed its end instruction.
- `instrucao_io`  in  1: running process issued an I/O instruction.
- `io_done`  in  1: I/O for `io_done_id` is complete.
- `io_done_id`  in  log2(NUM_PROC): slot whose I/O completed.
- `proc_load`  in  1: load a slot.
- `proc_load_id`  in  log2(NUM_PROC): slot to load.
- `proc_load_pc`  in  PC_W: start PC for the loaded slot.
- `troca_contexto`  out  1: one-cycle context-switch pulse.
- `pc_retorno`  out  PC_W: PC to load when `troca_contexto` is high.
- `processo_atual`  out  32: running slot, zero-extended.
- `intrucao_io_contexto`  out  1: high with `troca_contexto` when the switch cause was I/O.
- `ocioso`  out  1: no runnable slot.
- `quantum_restante`  out  8: instructions left in the slice.

## Operation
**Slot state:** per-slot `valid` bit and `pc_table` entry. `proc_load` sets `valid` and writes `pc_table`. If it targets the same slot as a save in the same cycle, the load wins.

**States:** IDLE, RUN, SAVE, SELECT, DISPATCH.
- **IDLE:** when `enable` is high and at least one slot is runnable, go to SELECT. Search starts at `processo_atual` inclusive.
- **RUN:** each `instr_valid` decrements the quantum. Go to SAVE on the first of these:
  - `fim_processo`
  - `instrucao_io`
  - the decrement reaching 0
- **RUN priority:** `fim_processo` > `instrucao_io` > expiry. `enable` low in RUN goes to IDLE without saving.
- **SAVE:**
  - `pc_table[atual]` <= `pc`.
  - On end: clear `valid[atual]`.
  - On I/O: latch the cause flag.
- **SELECT:**
  - Single-cycle circular search from `atual+1` (or inclusive start from IDLE), wrapping at `NUM_PROC-1` to 0.
  - If nothing is runnable, go to IDLE with `ocioso`=1.
  - If only the current slot is runnable, it is reselected.
- **DISPATCH:**
  - `processo_atual` <= selected slot.
  - `pc_retorno` <= `pc_table[sel]`.
  - `troca_contexto`=1.
  - `intrucao_io_contexto` = I/O cause flag.
  - Quantum reloaded to `QUANTUM`.
  - Go to RUN.

**Reset values:** state IDLE, all `valid`=0, `pc_table`=0, `processo_atual`=0, `pc_retorno`=0, `troca_contexto`=0, `intrucao_io_contexto`=0, `ocioso`=1, `quantum_restante`=`QUANTUM`. Reset mid-switch aborts with no pulse.

## Timing
- `troca_contexto` is a Moore output of DISPATCH: exactly one cycle wide, asserted in the third cycle after the edge that samples the causing event (RUN→SAVE→SELECT→DISPATCH).
- `pc_retorno` and `processo_atual` are registered and valid in the same cycle as the pulse; both hold until the next DISPATCH.
- Quantum decrements apply only in RUN. `instr_valid` in SAVE, SELECT or DISPATCH is ignored.
- Simultaneous `io_done` and `instrucao_io` for the same slot: the block flag (see Configuration) ends up set, because the save is applied after `io_done`.
- `ocioso` is combinational from the `valid`/block bits: 1 when no slot is runnable.

## Configuration
- **`SCHED_IO_BLOCK_EN` defined:**
  - An I/O switch sets `blocked[atual]`.
  - Runnable = `valid & ~blocked`.
  - `io_done` clears `blocked[io_done_id]`; a blocked slot is skipped by SELECT.
- **Undefined:**
  - No `blocked` state.
  - I/O only forces a switch; the slot stays runnable.
  - `io_done` and `io_done_id` are ignored.

## Test plan
- **Quantum round-robin:** `QUANTUM`=4, load slots 0 and 2, `enable`=1 → first DISPATCH to slot 0. After 4 `instr_valid`, `troca_contexto` is high 3 cycles later with `processo_atual`=2 and `pc_retorno` = slot 2 load PC.
- **PC save/restore:** slot 0 preempted at `pc`=0x2A → its next DISPATCH gives `pc_retorno`=0x2A.
- **End of process:** `fim_processo` with `instrucao_io` in the same cycle in slot 2 → `valid[2]`=0 and `intrucao_io_contexto`=0. With only slot 2 valid → IDLE, `ocioso`=1, no pulse.
- **I/O blocking (`SCHED_IO_BLOCK_EN`):** slots 0 and 1 valid, I/O in slot 1 → `intrucao_io_contexto`=1, slot 1 skipped until `io_done`(1), then scheduled on the next switch.
- **Reset and wrap:** `NUM_PROC`=8, slot 7 running, slot 0 valid → next is slot 0. Reset asserted in SELECT → no pulse, all outputs at reset values the next cycle.
